// File: rtl/adder_wb_pkg.sv
// -----------------------------------------------------------------------------
// adder_wb_pkg
// Shared definitions for the Wishbone-controlled adder block:
//   - register offsets as word indices (byte offset >> 2, matched on adr[7:2])
//   - CTRL and STATUS bit positions
//   - compute sequencer state encoding
// -----------------------------------------------------------------------------
package adder_wb_pkg;

  // Word indices: OPA 0x00, OPB 0x04, CTRL 0x08, RESULT 0x0C, STATUS 0x10
  localparam logic [5:0] OFS_OPA    = 6'h00;
  localparam logic [5:0] OFS_OPB    = 6'h01;
  localparam logic [5:0] OFS_CTRL   = 6'h02;
  localparam logic [5:0] OFS_RESULT = 6'h03;
  localparam logic [5:0] OFS_STATUS = 6'h04;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ACC      = 1;
  localparam int unsigned CTRL_PINSRC   = 2;
  localparam int unsigned CTRL_OE       = 3;
  localparam int unsigned CTRL_IRQ_MASK = 4;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_wb_core.sv
// -----------------------------------------------------------------------------
// adder_wb_core
// Compute sequencer for the bus-driven adder: IDLE -> LOAD -> ADD -> IDLE.
// LOAD captures the operands, ADD registers the WIDTH+1 bit sum, sets DONE
// and bumps the wrapping operation counter.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_start          start pulse (ignored unless IDLE)
//   i_clr_done       clear DONE (loses to a same-cycle set)
//   i_acc, i_pinsrc  operand source selects
//   i_opa, i_opb     register operands
//   i_pin_a, i_pin_b pin operands
//   o_result         last result {carry, sum}
//   o_done, o_busy   status flags
//   o_count          completed operation count
// -----------------------------------------------------------------------------
module adder_wb_core
  import adder_wb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_clr_done,
  input  logic             i_acc,
  input  logic             i_pinsrc,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  input  logic [WIDTH-1:0] i_pin_a,
  input  logic [WIDTH-1:0] i_pin_b,
  output logic [WIDTH:0]   o_result,
  output logic             o_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_result;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = ADD;
      ADD:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (r_state == LOAD) begin
        r_a <= i_pinsrc ? i_pin_a : i_opa;
        // Accumulate mode feeds the previous sum back in as operand b
        r_b <= i_acc ? r_result[WIDTH-1:0] : (i_pinsrc ? i_pin_b : i_opb);
      end
      if (r_state == ADD) begin
        r_result <= w_sum;
        r_count  <= r_count + 1'b1;
      end
      // Set has priority over a RESULT read in the same cycle
      if (r_state == ADD) begin
        r_done <= 1'b1;
      end else if (i_clr_done) begin
        r_done <= 1'b0;
      end
    end
  end

  assign o_result = r_result;
  assign o_done   = r_done;
  assign o_busy   = (r_state != IDLE);
  assign o_count  = r_count;

endmodule

// File: rtl/adder_wb_regs.sv
// -----------------------------------------------------------------------------
// adder_wb_regs
// Wishbone classic responder exposing the 8-bit adder to the management SoC.
// Decodes adr[31:8] against BASE_ADDR, acks one cycle after a hit (never on
// consecutive cycles), holds OPA/OPB/CTRL and registers read data into the
// ack cycle. The compute sequencer lives in adder_wb_core.
// Optional feature macro: ADDER_WB_IRQ_EN (user_irq = DONE gated by
// CTRL[4] IRQ_MASK); when undefined user_irq is 0 and CTRL[4] is absent.
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i     bus cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i     byte selects, byte address
//   wbs_dat_i / wbs_dat_o    write / read data
//   wbs_ack_o                acknowledge
//   io_in                    pin operands {b, a}
//   io_out, io_oeb           last result, active-low output enables
//   user_irq                 done interrupt
// -----------------------------------------------------------------------------
module adder_wb_regs
  import adder_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [15:0] io_in,
  output logic [8:0]  io_out,
  output logic [8:0]  io_oeb,
  output logic        user_irq
);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_acc;
  logic             r_pinsrc;
  logic             r_oe;
`ifdef ADDER_WB_IRQ_EN
  logic             r_irq_mask;
`endif

  logic             w_hit;
  logic             w_wr;
  logic             w_rd;
  logic [5:0]       w_ofs;
  logic             w_start;
  logic             w_clr_done;
  logic [31:0]      w_rdata;
  logic [WIDTH:0]   w_result;
  logic             w_done;
  logic             w_busy;
  logic [CNT_W-1:0] w_count;
  logic             w_unused;

  // Blocking on r_ack forces at least one idle cycle between acks
  assign w_hit = wbs_cyc_i & wbs_stb_i & ~r_ack &
                 (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_wr  = w_hit & wbs_we_i & wbs_sel_i[0];
  assign w_rd  = w_hit & ~wbs_we_i;
  assign w_ofs = wbs_adr_i[7:2];

  assign w_start    = w_wr & (w_ofs == OFS_CTRL) & wbs_dat_i[CTRL_START];
  assign w_clr_done = w_rd & (w_ofs == OFS_RESULT);

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_OPA:    w_rdata[WIDTH-1:0] = r_opa;
      OFS_OPB:    w_rdata[WIDTH-1:0] = r_opb;
      OFS_CTRL: begin
        w_rdata[CTRL_ACC]    = r_acc;
        w_rdata[CTRL_PINSRC] = r_pinsrc;
        w_rdata[CTRL_OE]     = r_oe;
`ifdef ADDER_WB_IRQ_EN
        w_rdata[CTRL_IRQ_MASK] = r_irq_mask;
`endif
      end
      OFS_RESULT: w_rdata[WIDTH:0] = w_result;
      OFS_STATUS: begin
        w_rdata[STAT_BUSY]               = w_busy;
        w_rdata[STAT_DONE]               = w_done;
        w_rdata[STAT_CNT_LSB +: CNT_W]   = w_count;
      end
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_acc      <= 1'b0;
      r_pinsrc   <= 1'b0;
      r_oe       <= 1'b0;
`ifdef ADDER_WB_IRQ_EN
      r_irq_mask <= 1'b0;
`endif
    end else begin
      r_ack <= w_hit;
      r_dat <= w_rd ? w_rdata : '0;
      if (w_wr) begin
        case (w_ofs)
          OFS_OPA: r_opa <= wbs_dat_i[WIDTH-1:0];
          OFS_OPB: r_opb <= wbs_dat_i[WIDTH-1:0];
          OFS_CTRL: begin
            r_acc    <= wbs_dat_i[CTRL_ACC];
            r_pinsrc <= wbs_dat_i[CTRL_PINSRC];
            r_oe     <= wbs_dat_i[CTRL_OE];
`ifdef ADDER_WB_IRQ_EN
            r_irq_mask <= wbs_dat_i[CTRL_IRQ_MASK];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  adder_wb_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .i_start    (w_start),
    .i_clr_done (w_clr_done),
    .i_acc      (r_acc),
    .i_pinsrc   (r_pinsrc),
    .i_opa      (r_opa),
    .i_opb      (r_opb),
    .i_pin_a    (io_in[WIDTH-1:0]),
    .i_pin_b    (io_in[8 +: WIDTH]),
    .o_result   (w_result),
    .o_done     (w_done),
    .o_busy     (w_busy),
    .o_count    (w_count)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = w_result;
  assign io_oeb    = {9{~r_oe}};

`ifdef ADDER_WB_IRQ_EN
  assign user_irq = w_done & ~r_irq_mask;
`else
  assign user_irq = 1'b0;
`endif

  // Bus bits with no register behind them
  assign w_unused = ^{wbs_dat_i, wbs_sel_i[3:1], wbs_adr_i[1:0], io_in};

endmodule

// File: doc/adder_wb_regs.md
Name: adder_wb_regs

Overview:
- Wishbone classic responder that lets the management SoC drive the user-area 8-bit adder over the bus, instead of the operands coming only from the io_in pins.
- Holds operand registers, runs a small compute sequencer, and returns sum/carry, status and an operation count.
- Sits inside the user project wrapper between the wbs_* bus and the adder datapath; io_out mirrors the latest result.

Parameters:
- BASE_ADDR, 32'h3000_0000, register window base; decode compares adr[31:8] only.
- WIDTH, 8, operand width; result is WIDTH+1 bits.
- CNT_W, 8, operation counter width.

Ports:
- wb_clk_i  input  1  the single clock.
- wb_rst_ni  input  1  reset; asynchronous, active-low.
- wbs_cyc_i  input  1  bus cycle.
- wbs_stb_i  input  1  strobe.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- io_in  input  16  pin operands: [7:0] a, [15:8] b.
- io_out  output  9  last result {carry, sum}.
- io_oeb  output  9  output enables, active-low.
- user_irq  output  1  done interrupt (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all registers 0, FSM IDLE, wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=all 1, user_irq=0.
- Hit condition: cyc&stb&(adr[31:8]==BASE_ADDR[31:8])&!ack.
- On a hit, ack rises the next cycle for exactly one cycle, then is low for at least one cycle. Misses are never acked.
- Register map, by adr[7:2]. All registers write only when sel[0]=1.
  - 0x00 OPA: RW [7:0].
  - 0x04 OPB: RW [7:0].
  - 0x08 CTRL: [0] START (write-1 pulse, reads 0); [1] ACC (RW); [2] PINSRC (RW); [3] OE (RW).
  - 0x0C RESULT: RO [8:0]. A read clears STATUS.DONE.
  - 0x10 STATUS: RO [0] BUSY, [1] DONE, [15:8] op count.
  - Other offsets: acked, read 0, writes ignored.
- Read data is registered and valid in the ack cycle.
- FSM: IDLE -> LOAD -> ADD -> IDLE.
  - START while IDLE -> LOAD. LOAD latches operands: a = PINSRC ? io_in[7:0] : OPA; b = ACC ? RESULT[7:0] : (PINSRC ? io_in[15:8] : OPB).
  - ADD: RESULT <= a+b (9 bits, carry in bit 8); DONE <= 1; count++ (wraps at 2^CNT_W, no saturation); return to IDLE.
  - BUSY = (state != IDLE).
  - Latency: START written in cycle N (ack at N+1) gives RESULT valid and DONE=1 at N+3.
- START while BUSY is ignored; no queueing, count unchanged.
- Same-cycle DONE set (ADD) and RESULT read: set wins, DONE stays 1.
- Writing OPA/OPB while BUSY is allowed; the in-flight operation uses values already latched in LOAD.
- io_out = RESULT; io_oeb = {9{~OE}}.
- Reset mid-operation: FSM returns to IDLE; RESULT and count clear.

Optional Feature:
- Macro ADDER_WB_IRQ_EN.
- Defined: user_irq = DONE level; CTRL[4] IRQ_MASK (RW, 1 = masked) gates it.
- Undefined: user_irq tied 0; CTRL[4] reads 0 and writes are ignored.

Decomposition:
- Package adder_wb_pkg: register offsets (OFS_OPA, OFS_OPB, OFS_CTRL, OFS_RESULT, OFS_STATUS), CTRL bit indices, FSM state enum (IDLE, LOAD, ADD).
- One sub-module, adder_wb_core: the FSM, operand latches, add and counter. Bus decode and ack logic stay in the top.

Test Plan:
- Reset then read STATUS -> 0x0000_0000, io_oeb=9'h1FF, io_out=0.
- Write OPA=0xC8, OPB=0x64, CTRL=0x9 -> three cycles after the write's ack, RESULT=0x12C, STATUS=0x0102, io_out=9'h12C, io_oeb=0.
- Read RESULT -> 0x12C, after which STATUS.DONE=0. Then CTRL=0x3 (ACC) with OPA=0x01 -> RESULT=0x02D.
- PINSRC: io_in=16'hFF01, CTRL=0x5 -> RESULT=0x100. Second START issued while BUSY -> count advances by 1 only.
- Access to adr 0x3000_0100 -> no ack. Access to 0x3000_0014 -> ack, data 0. Ack never asserted on consecutive cycles.
- Drop wb_rst_ni for 1 cycle in LOAD -> all outputs reset immediately; a later START works normally. With ADDER_WB_IRQ_EN: DONE=1 drives user_irq high; setting CTRL[4] drives it low.
